// File: rtl/af_pkg.sv
// Auto-focus sweep sequencer: shared state encoding and parameter defaults.
package af_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_SETTLE,
      ST_MEASURE,
      ST_NEXT,
      ST_FINAL
   } state_e;

   localparam int unsigned POS_W_DEF         = 10;
   localparam int unsigned POS_MIN_DEF       = 0;
   localparam int unsigned POS_MAX_DEF       = 1023;
   localparam int unsigned STEP_DEF          = 64;
   localparam int unsigned SETTLE_FRAMES_DEF = 2;
   localparam int unsigned FV_W_DEF          = 32;
   localparam int unsigned TIMEOUT_DEF       = 50000;

endpackage

// File: rtl/af_sweep_ctrl_if.sv
// VCM position-write handshake towards the I2C master.
//   vcm_req : write request, held until ack or timeout
//   vcm_pos : position to write, stable while vcm_req=1
//   vcm_ack : one-cycle write-complete pulse
interface af_sweep_ctrl_if
   import af_pkg::*;
#(
   parameter int unsigned POS_W = POS_W_DEF
) ();

   logic             vcm_req;
   logic [POS_W-1:0] vcm_pos;
   logic             vcm_ack;

   modport master (output vcm_req, output vcm_pos, input vcm_ack);
   modport slave  (input vcm_req, input vcm_pos, output vcm_ack);

endinterface

// File: rtl/af_peak_tracker.sv
// Keeps the sharpest (position, focus value) pair seen since the last clear.
//   clr_i        : forget all samples
//   load_i       : a new sample (pos_i, value_i) is offered this cycle
//   best_pos_o   : position of the best sample
//   best_value_o : focus value of the best sample
module af_peak_tracker
   import af_pkg::*;
#(
   parameter int unsigned POS_W = POS_W_DEF,
   parameter int unsigned FV_W  = FV_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [POS_W-1:0] pos_i,
   input  logic [FV_W-1:0]  value_i,
   output logic [POS_W-1:0] best_pos_o,
   output logic [FV_W-1:0]  best_value_o
);

   logic             has_q, has_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [FV_W-1:0]  val_q, val_d;

   // Strictly greater replaces, so ties keep the earlier (lower) position.
   always_comb begin
      has_d = has_q;
      pos_d = pos_q;
      val_d = val_q;
      if (clr_i) begin
         has_d = 1'b0;
         pos_d = '0;
         val_d = '0;
      end else if (load_i && (!has_q || (value_i > val_q))) begin
         has_d = 1'b1;
         pos_d = pos_i;
         val_d = value_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         has_q <= 1'b0;
         pos_q <= '0;
         val_q <= '0;
      end else begin
         has_q <= has_d;
         pos_q <= pos_d;
         val_q <= val_d;
      end
   end

   assign best_pos_o   = pos_q;
   assign best_value_o = val_q;

endmodule

// File: rtl/af_sweep_ctrl.sv
// Auto-focus sweep sequencer: steps the VCM from POS_MIN to POS_MAX by STEP,
// samples focus after settling, then parks the lens at the sharpest position.
//   start/abort  : one-cycle control pulses
//   frame_done   : frame-end pulse, focus_value valid with it
//   vcm          : position-write handshake (master side)
//   busy/done    : sweep in progress / final write acknowledged
//   error        : sticky ack timeout, cleared by the next accepted start
//   best_pos/best_value : sharpest sample of the sweep
module af_sweep_ctrl
   import af_pkg::*;
#(
   parameter int unsigned POS_W         = POS_W_DEF,
   parameter int unsigned POS_MIN       = POS_MIN_DEF,
   parameter int unsigned POS_MAX       = POS_MAX_DEF,
   parameter int unsigned STEP          = STEP_DEF,
   parameter int unsigned SETTLE_FRAMES = SETTLE_FRAMES_DEF,
   parameter int unsigned FV_W          = FV_W_DEF,
   parameter int unsigned TIMEOUT       = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic              frame_done,
   input  logic [FV_W-1:0]   focus_value,
   af_sweep_ctrl_if.master   vcm,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [POS_W-1:0]  best_pos,
   output logic [FV_W-1:0]   best_value
);

   localparam int unsigned POS_W1 = POS_W + 1;
   localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned SC_W   = (SETTLE_FRAMES < 2) ? 1 : $clog2(SETTLE_FRAMES + 1);

   state_e           state_q, state_d;
   logic [POS_W-1:0] cur_q, cur_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             req_q, req_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [SC_W-1:0]  settle_q, settle_d;
   logic             abort_pend_q, abort_pend_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             trk_clr_c, trk_load_c;
   logic             ack_c, timeout_c;
   logic [POS_W1-1:0] next_pos_c;

   // Extra bit so the increment can never wrap past the top of the range.
   assign next_pos_c = POS_W1'(cur_q) + POS_W1'(STEP);
   assign ack_c      = req_q && vcm.vcm_ack;
   assign timeout_c  = req_q && !vcm.vcm_ack && (to_q == TO_W'(TIMEOUT - 1));

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      pos_d        = pos_q;
      req_d        = req_q;
      to_d         = req_q ? (to_q + TO_W'(1)) : '0;
      settle_d     = settle_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;
      error_d      = error_q;
      trk_clr_c    = 1'b0;
      trk_load_c   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_WRITE;
               error_d      = 1'b0;
               trk_clr_c    = 1'b1;
               settle_d     = '0;
               abort_pend_d = 1'b0;
               cur_d        = POS_W'(POS_MIN);
               pos_d        = POS_W'(POS_MIN);
               req_d        = 1'b1;
               to_d         = '0;
            end
         end
         ST_WRITE, ST_FINAL: begin
            // Ack wins over timeout; a pending or coincident abort turns the ack into an exit.
            if (ack_c) begin
               req_d = 1'b0;
               if (abort_pend_q || abort) begin
                  state_d = ST_IDLE;
               end else if (state_q == ST_FINAL) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else if (SETTLE_FRAMES == 0) begin
                  state_d = ST_MEASURE;
               end else begin
                  state_d  = ST_SETTLE;
                  settle_d = '0;
               end
            end else if (timeout_c) begin
               req_d   = 1'b0;
               error_d = 1'b1;
               state_d = ST_IDLE;
            end else if (abort) begin
               abort_pend_d = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (frame_done) begin
               if (settle_q == SC_W'(SETTLE_FRAMES - 1)) begin
                  state_d  = ST_MEASURE;
                  settle_d = '0;
               end else begin
                  settle_d = settle_q + SC_W'(1);
               end
            end
         end
         ST_MEASURE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (frame_done) begin
               trk_load_c = 1'b1;
               state_d    = ST_NEXT;
            end
         end
         ST_NEXT: begin
            req_d = 1'b1;
            if (next_pos_c > POS_W1'(POS_MAX)) begin
               state_d = ST_FINAL;
               pos_d   = best_pos;
            end else begin
               state_d = ST_WRITE;
               cur_d   = POS_W'(next_pos_c);
               pos_d   = POS_W'(next_pos_c);
            end
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         cur_q        <= '0;
         pos_q        <= '0;
         req_q        <= 1'b0;
         to_q         <= '0;
         settle_q     <= '0;
         abort_pend_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         pos_q        <= pos_d;
         req_q        <= req_d;
         to_q         <= to_d;
         settle_q     <= settle_d;
         abort_pend_q <= abort_pend_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   af_peak_tracker #(
      .POS_W (POS_W),
      .FV_W  (FV_W)
   ) u_peak (
      .clk          (clk),
      .reset_n      (reset_n),
      .clr_i        (trk_clr_c),
      .load_i       (trk_load_c),
      .pos_i        (cur_q),
      .value_i      (focus_value),
      .best_pos_o   (best_pos),
      .best_value_o (best_value)
   );

   assign vcm.vcm_req = req_q;
   assign vcm.vcm_pos = pos_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule
